// File: rtl/nfc_multi_page_copy.sv
`default_nettype none
// ============================================================================
// nfc_multi_page_copy - reads pages from NAND A and programs them into NAND B
// Rev 1.0
// ============================================================================
module nfc_multi_page_copy #(
  parameter int PAGE_BYTES = 512,
  parameter int ROW_AW     = 9,
  parameter int COL_CYC    = 1,
  parameter int RB_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_AW-1:0] first_page,
  input  logic [ROW_AW:0]   page_count,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ROW_AW:0]   pages_done,
  inout  wire  [7:0]        F_IO_A,
  output logic              F_CLE_A,
  output logic              F_ALE_A,
  output logic              F_REN_A,
  output logic              F_WEN_A,
  input  logic              F_RB_A,
  inout  wire  [7:0]        F_IO_B,
  output logic              F_CLE_B,
  output logic              F_ALE_B,
  output logic              F_REN_B,
  output logic              F_WEN_B,
  input  logic              F_RB_B,
  output logic              F_IO_A_READING,
  output logic              F_IO_B_READING
);

  localparam int ROW_CYC     = (ROW_AW + 7) / 8;
  localparam int ADDR_CYCLES = 2 * (COL_CYC + ROW_CYC);
  localparam int XFER_CYCLES = 2 * PAGE_BYTES;
  localparam int MAX_A       = (XFER_CYCLES > ADDR_CYCLES) ? XFER_CYCLES : ADDR_CYCLES;
  localparam int MAX_CNT     = (MAX_A > RB_TIMEOUT) ? MAX_A : RB_TIMEOUT;
  localparam int CNT_W       = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  XFER_LAST = CNT_W'(XFER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RB_LAST   = CNT_W'(RB_TIMEOUT - 1);
  localparam logic [ROW_AW:0]   REM_ONE   = (ROW_AW+1)'(1);
  localparam logic [ROW_AW-1:0] PAGE_ONE  = ROW_AW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WAIT_A = 3'd3;
  localparam logic [2:0] S_XFER   = 3'd4;
  localparam logic [2:0] S_PROG   = 3'd5;
  localparam logic [2:0] S_WAIT_B = 3'd6;
  localparam logic [2:0] S_ABORT  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROW_AW-1:0] page_q, page_d;
  logic [ROW_AW:0]   remaining_q, remaining_d;
  logic [ROW_AW:0]   pages_done_q, pages_done_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              rb_low_q, rb_low_d;
  logic [7:0]        xfer_byte_q, xfer_byte_d;

  logic [ROW_CYC*8-1:0] page_pad;
  logic [31:0]          byte_idx;
  logic [7:0]           addr_byte;
  logic [7:0]           io_a_drv;
  logic [7:0]           io_b_drv;
  logic                 rb_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      page_q        <= '0;
      remaining_q   <= '0;
      pages_done_q  <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rb_low_q      <= 1'b0;
      xfer_byte_q   <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      page_q        <= page_d;
      remaining_q   <= remaining_d;
      pages_done_q  <= pages_done_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      rb_low_q      <= rb_low_d;
      xfer_byte_q   <= xfer_byte_d;
    end
  end

  assign rb_sel = (state_q == S_WAIT_A) ? F_RB_A : F_RB_B;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    page_d        = page_q;
    remaining_d   = remaining_q;
    pages_done_d  = pages_done_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    rb_low_d      = rb_low_q;
    xfer_byte_d   = xfer_byte_q;
    case (state_q)
      S_IDLE: begin
        // A start landing on the done cycle is deliberately dropped.
        if (start && !done_q) begin
          page_d        = first_page;
          remaining_d   = page_count;
          pages_done_d  = '0;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          if (page_count == '0) done_d = 1'b1;
          else                  state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          state_d  = S_WAIT_A;
          cnt_d    = '0;
          rb_low_d = 1'b0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      S_XFER: begin
        if (!cnt_q[0]) xfer_byte_d = F_IO_A;
        if (cnt_q == XFER_LAST) begin
          state_d = S_PROG;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      S_PROG: begin
        if (cnt_q == CNT_ONE) begin
          state_d  = S_WAIT_B;
          cnt_d    = '0;
          rb_low_d = 1'b0;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      S_WAIT_A, S_WAIT_B: begin
        // Completion needs a busy (low) period before ready is trusted.
        if (rb_low_q && rb_sel) begin
          cnt_d = '0;
          if (state_q == S_WAIT_A) state_d = S_XFER;
          else begin
            pages_done_d = pages_done_q + REM_ONE;
            page_d       = page_q + PAGE_ONE;
            remaining_d  = remaining_q - REM_ONE;
            if (remaining_q == REM_ONE) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else state_d = S_CMD;
          end
        end else if (cnt_q == RB_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (!rb_sel) rb_low_d = 1'b1;
        end
      end
      S_ABORT: begin
        state_d       = S_IDLE;
        done_d        = 1'b1;
        timeout_err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    page_pad                = '0;
    page_pad[ROW_AW-1:0]    = page_q;
    byte_idx                = 32'(cnt_q >> 1);
    addr_byte               = 8'h00;
    for (int k = 0; k < ROW_CYC; k++) begin
      if (byte_idx == 32'(COL_CYC + k)) addr_byte = page_pad[k*8 +: 8];
    end
  end

  always_comb begin
    F_CLE_A        = 1'b0;
    F_ALE_A        = 1'b0;
    F_REN_A        = 1'b1;
    F_WEN_A        = 1'b1;
    F_CLE_B        = 1'b0;
    F_ALE_B        = 1'b0;
    F_REN_B        = 1'b1;
    F_WEN_B        = 1'b1;
    F_IO_A_READING = 1'b0;
    F_IO_B_READING = 1'b0;
    io_a_drv       = 8'h00;
    io_b_drv       = 8'h00;
    case (state_q)
      S_CMD: begin
        F_CLE_A  = 1'b1;
        F_CLE_B  = 1'b1;
        F_WEN_A  = cnt_q[0];
        F_WEN_B  = cnt_q[0];
        io_b_drv = 8'h80;
      end
      S_ADDR: begin
        F_ALE_A  = 1'b1;
        F_ALE_B  = 1'b1;
        F_WEN_A  = cnt_q[0];
        F_WEN_B  = cnt_q[0];
        io_a_drv = addr_byte;
        io_b_drv = addr_byte;
      end
      S_WAIT_A: F_IO_A_READING = 1'b1;
      S_XFER: begin
        F_IO_A_READING = 1'b1;
        F_REN_A        = cnt_q[0];
        F_WEN_B        = cnt_q[0];
        io_b_drv       = cnt_q[0] ? xfer_byte_q : F_IO_A;
      end
      S_PROG: begin
        F_CLE_B  = 1'b1;
        F_WEN_B  = cnt_q[0];
        io_b_drv = 8'h10;
      end
      default: ;
    endcase
  end

  assign F_IO_A      = F_IO_A_READING ? 8'hzz : io_a_drv;
  assign F_IO_B      = io_b_drv;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign pages_done  = pages_done_q;

endmodule
`default_nettype wire

// File: tb/tb_nfc_multi_page_copy.sv
`default_nettype none
// Bench for nfc_multi_page_copy: two parameter sets driven against NAND models,
// with expected bus traffic built from page numbers and data rules.
module tb_nfc_multi_page_copy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       start   = '0;
  logic [1:0]       stuck_b = '0;
  logic [1:0][16:0] fp_r    = '0;
  logic [1:0][17:0] pc_r    = '0;
  wire  [1:0]       busy_w, done_w, err_w;
  wire  [1:0][17:0] pd_w;
  wire  [1:0][25:0] ctl_w;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] salt = 8'h00;
  logic [9:0] alog0[$], alog1[$], blog0[$], blog1[$];
  logic [9:0] ea[$], eb[$];
  int last10_0 = 0, last10_1 = 0;
  int tests = 0, fails = 0;

  function automatic logic [7:0] dat(input int pg, input int i);
    return 8'(i + pg * 7) ^ salt;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int PB  = (g == 0) ? 512 : 16;
    localparam int RAW = (g == 0) ? 9 : 17;
    localparam int CC  = (g == 0) ? 1 : 2;
    localparam int RBT = (g == 0) ? 4096 : 64;
    localparam int RC  = (RAW + 7) / 8;

    wire [7:0] io_a, io_b;
    wire cle_a, ale_a, ren_a, wen_a, cle_b, ale_b, ren_b, wen_b, rd_a, rd_b;
    wire [RAW:0] pd;
    logic [7:0]  a_out;
    logic [23:0] row_a = '0;
    int ac_a = 0, idx = 0, ta = 0, tb = 0;
    logic pw_a = 1'b1, pw_b = 1'b1, pr_a = 1'b1;
    wire rb_a = !(ta >= 1 && ta <= 20);
    wire rb_b = !(tb >= 1 && tb <= 20);

    assign a_out = dat(int'(row_a), idx);
    assign io_a  = rd_a ? a_out : 8'hzz;

    nfc_multi_page_copy #(
      .PAGE_BYTES(PB), .ROW_AW(RAW), .COL_CYC(CC), .RB_TIMEOUT(RBT)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .first_page(fp_r[g][RAW-1:0]), .page_count(pc_r[g][RAW:0]),
      .busy(busy_w[g]), .done(done_w[g]), .timeout_err(err_w[g]), .pages_done(pd),
      .F_IO_A(io_a), .F_CLE_A(cle_a), .F_ALE_A(ale_a), .F_REN_A(ren_a), .F_WEN_A(wen_a),
      .F_RB_A(rb_a),
      .F_IO_B(io_b), .F_CLE_B(cle_b), .F_ALE_B(ale_b), .F_REN_B(ren_b), .F_WEN_B(wen_b),
      .F_RB_B(rb_b),
      .F_IO_A_READING(rd_a), .F_IO_B_READING(rd_b)
    );

    assign pd_w[g]  = 18'(pd);
    assign ctl_w[g] = {io_a, io_b, cle_a, ale_a, wen_a, ren_a,
                       cle_b, ale_b, wen_b, ren_b, rd_a, rd_b};

    // NAND behaviour: latch on WEN rise, busy 3 cycles after the last
    // address byte / program confirm, low for 20 cycles.
    always @(negedge clk) begin
      pw_a <= wen_a;
      pw_b <= wen_b;
      pr_a <= ren_a;
      if (rst) begin
        ac_a <= 0;
        idx  <= 0;
        ta   <= 0;
        tb   <= 0;
      end else begin
        if (ta > 0) ta <= ta - 1;
        if (tb > 0) tb <= tb - 1;
        if (!pw_a && wen_a) begin
          if (g == 0) alog0.push_back({cle_a, ale_a, io_a});
          else        alog1.push_back({cle_a, ale_a, io_a});
          if (cle_a) ac_a <= 0;
          if (ale_a) begin
            if (ac_a >= CC && ac_a < CC + RC) row_a[(ac_a - CC) * 8 +: 8] <= io_a;
            ac_a <= ac_a + 1;
            if (ac_a == CC + RC - 1) begin
              ta  <= 23;
              idx <= 0;
            end
          end
        end
        if (!pr_a && ren_a) idx <= idx + 1;
        if (!pw_b && wen_b) begin
          if (g == 0) blog0.push_back({cle_b, ale_b, io_b});
          else        blog1.push_back({cle_b, ale_b, io_b});
          if (cle_b && io_b == 8'h10) begin
            if (g == 0) last10_0 <= cyc;
            else        last10_1 <= cyc;
            if (!stuck_b[g]) tb <= 23;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_logs();
    alog0.delete(); alog1.delete(); blog0.delete(); blog1.delete();
  endtask

  // Expected traffic of a copy, derived from the page numbers only.
  task automatic build_exp(input int inst, input int fp, input int npg);
    int pb, raw, cc, rc, pg;
    logic [7:0] b;
    pb  = (inst != 0) ? 16 : 512;
    raw = (inst != 0) ? 17 : 9;
    cc  = (inst != 0) ? 2 : 1;
    rc  = (raw + 7) / 8;
    ea.delete();
    eb.delete();
    for (int p = 0; p < npg; p++) begin
      pg = (fp + p) % (1 << raw);
      ea.push_back({2'b10, 8'h00});
      eb.push_back({2'b10, 8'h80});
      for (int c = 0; c < cc + rc; c++) begin
        b = (c < cc) ? 8'h00 : 8'(pg >> (8 * (c - cc)));
        ea.push_back({2'b01, b});
        eb.push_back({2'b01, b});
      end
      for (int i = 0; i < pb; i++) eb.push_back({2'b00, dat(pg, i)});
      eb.push_back({2'b10, 8'h10});
    end
  endtask

  task automatic cmp_logs(input int inst, input string tag);
    logic [9:0] qa[$], qb[$];
    int bad;
    if (inst == 0) begin qa = alog0; qb = blog0; end
    else           begin qa = alog1; qb = blog1; end
    chk({tag, " a_strobes"}, qa.size(), ea.size());
    bad = 0;
    for (int i = 0; i < qa.size() && i < ea.size(); i++) if (qa[i] !== ea[i]) bad++;
    chk({tag, " a_bytes_wrong"}, bad, 0);
    chk({tag, " b_strobes"}, qb.size(), eb.size());
    bad = 0;
    for (int i = 0; i < qb.size() && i < eb.size(); i++) if (qb[i] !== eb[i]) bad++;
    chk({tag, " b_bytes_wrong"}, bad, 0);
  endtask

  task automatic run_copy(input string tag, input int inst, input int fp, input int pc,
                          input bit stuck, input int exp_pd, input bit exp_err);
    int dones, done_k, dcyc, l10;
    bit busy_seen;
    build_exp(inst, fp, stuck ? 1 : pc);
    clr_logs();
    @(negedge clk);
    stuck_b[inst] = stuck;
    fp_r[inst]    = 17'(fp);
    pc_r[inst]    = 18'(pc);
    start[inst]   = 1'b1;
    @(negedge clk);
    // Zero-count launches keep start high into the done cycle: must be ignored.
    if (pc != 0) start[inst] = 1'b0;
    chk({tag, " busy_after_start"}, busy_w[inst], (pc != 0));
    dones = 0; done_k = -1; dcyc = 0; busy_seen = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (k == 1) start[inst] = 1'b0;
      if (busy_w[inst]) busy_seen = 1'b1;
      if (done_w[inst]) begin
        dones++;
        if (done_k < 0) begin
          done_k = k;
          dcyc   = cyc;
          chk({tag, " busy_at_done"}, busy_w[inst], 0);
        end
      end
      if (done_k >= 0 && k >= done_k + 4) break;
      @(negedge clk);
    end
    chk({tag, " done_pulses"}, dones, 1);
    if (pc == 0) begin
      chk({tag, " zero_done_latency"}, done_k, 0);
      chk({tag, " zero_busy_seen"}, busy_seen, 0);
    end
    chk({tag, " pages_done"}, pd_w[inst], exp_pd);
    chk({tag, " timeout_err"}, err_w[inst], exp_err);
    if (stuck) begin
      l10 = (inst == 0) ? last10_0 : last10_1;
      chk({tag, " wait_b_to_done"}, dcyc - l10, 66);
    end
    cmp_logs(inst, tag);
  endtask

  typedef struct {
    int inst;
    int fp;
    int pc;
    bit stuck;
    int exp_pd;
    bit exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 0,      1, 1'b0, 1, 1'b0};
    tbl[1] = '{0, 510,    3, 1'b0, 3, 1'b0};
    tbl[2] = '{0, 5,      0, 1'b0, 0, 1'b0};
    tbl[3] = '{1, 131071, 2, 1'b0, 2, 1'b0};
    tbl[4] = '{1, 7,      2, 1'b1, 0, 1'b1};
    tbl[5] = '{1, 3,      1, 1'b0, 1, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset ctl", ctl_w[g], 26'h00000CC);
      chk("reset status", {busy_w[g], done_w[g], err_w[g]}, 3'b000);
      chk("reset pages_done", pd_w[g], 0);
    end
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      run_copy($sformatf("vec%0d", v), tbl[v].inst, tbl[v].fp, tbl[v].pc,
               tbl[v].stuck, tbl[v].exp_pd, tbl[v].exp_err);

    for (int r = 0; r < 6; r++) begin
      int fp, pc;
      salt = 8'($urandom);
      fp   = (r % 2 == 1) ? 131071 - r : int'($urandom_range(0, 131071));
      pc   = int'($urandom_range(1, 3));
      run_copy($sformatf("rand%0d", r), 1, fp, pc, 1'b0, pc, 1'b0);
    end

    // Reset in the middle of a page transfer.
    salt = 8'h00;
    clr_logs();
    @(negedge clk);
    stuck_b[0] = 1'b0;
    fp_r[0]    = 17'd2;
    pc_r[0]    = 18'd2;
    start[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (ctl_w[0][6] == 1'b0) break;
      @(negedge clk);
    end
    chk("rst_mid reached_xfer", ctl_w[0][6], 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid ctl", ctl_w[0], 26'h00000CC);
    chk("rst_mid status", {busy_w[0], done_w[0], err_w[0]}, 3'b000);
    chk("rst_mid pages_done", pd_w[0], 0);
    rst = 1'b0;
    run_copy("post_rst", 0, 4, 1, 1'b0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nfc_multi_page_copy.md
Name: nfc_multi_page_copy

Overview:
- Parametrised NAND-to-NAND page copy engine and successor to the fixed 512-page copier.
- Reads pages from flash A and streams each byte into a program operation on flash B.
- Adds the following over the fixed copier:
  - start/busy/done handshake
  - programmable start page and page count
  - configurable page size and address cycles
  - ready/busy timeout with a sticky error
- Sits between the flash-side pads (tristate IO on each bus) and the system controller that launches copies.

Parameters:
PAGE_BYTES, 512, bytes per page; power of two, minimum 2.
ROW_AW, 9, page (row) address width; row address cycles ROW_CYC = ceil(ROW_AW/8).
COL_CYC, 1, column address cycles; each drives 8'h00.
RB_TIMEOUT, 4096, maximum cycles spent in any ready/busy wait phase.

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle launch pulse; ignored while busy=1
first_page  in  ROW_AW  first page address, sampled on accepted start
page_count  in  ROW_AW+1  pages to copy, sampled on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse, both normal and abort
timeout_err  out  1  sticky; set on timeout, cleared on the next accepted start
pages_done  out  ROW_AW+1  pages fully programmed since the last start
F_IO_A  inout  8  flash A data bus
F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A  out  1 each  flash A control
F_RB_A  in  1  flash A ready/busy (1 = ready)
F_IO_B  inout  8  flash B data bus
F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B  out  1 each  flash B control
F_RB_B  in  1  flash B ready/busy
F_IO_A_READING, F_IO_B_READING  out  1 each  1 = bus released (8'hZZ), controller samples it

Behaviour:
- Reset values:
  - CLE, ALE = 0 on both buses; WEN, REN = 1 on both buses.
  - *_READING = 0; busy, done, timeout_err = 0; pages_done = 0; state = IDLE; IO outputs = 8'h00.
- Write strobe: every command/address/data write is 2 cycles. Cycle 1: WEN = 0 with value on IO. Cycle 2: WEN = 1 with value held; the flash latches on the WEN rise.
- IDLE: accepted start latches the page pointer and remaining count, clears pages_done and timeout_err. If page_count == 0, pulse done the next cycle, busy stays 0, no flash activity. Otherwise go to CMD.
- CMD, 2 cycles: CLE = 1 on both buses. A gets 8'h00, B gets 8'h80.
- ADDR, 2*(COL_CYC+ROW_CYC) cycles: ALE = 1 on both buses.
  - COL_CYC bytes of 8'h00 first.
  - Then row bytes LSB first: page[7:0], page[15:8], ...
  - The final row byte is zero-padded above bit ROW_AW-1.
  - Identical bytes go to A and B.
- WAIT_A:
  - ALE = 0; F_IO_A_READING = 1.
  - Require F_RB_A = 0 then F_RB_A = 1.
  - Cycle counter restarts on entry; reaching RB_TIMEOUT goes to ABORT.
- XFER, 2*PAGE_BYTES cycles, 2 per byte:
  - Phase 0: REN_A = 0, WEN_B = 0, F_IO_B = F_IO_A (combinational pass-through).
  - Phase 1: REN_A = 1, WEN_B = 1, F_IO_B held at the value captured in phase 0. B latches on the rise.
  - The byte counter wraps at PAGE_BYTES and triggers the exit.
- PROG, 2 cycles: F_IO_A_READING = 0; CLE_B = 1; B gets 8'h10.
- WAIT_B:
  - F_RB_B = 0 then F_RB_B = 1 required; same timeout rule as WAIT_A.
  - On completion: pages_done += 1, page pointer += 1 modulo 2^ROW_AW (wraps 2^ROW_AW-1 -> 0), remaining -= 1.
  - If remaining == 0: done pulse, busy = 0, IDLE. Else CMD.
- ABORT, 1 cycle:
  - All controls return to reset values; *_READING = 0.
  - timeout_err = 1, done pulse, IDLE. pages_done keeps the completed count.
- F_IO_B_READING is always 0 and B is always driven.
- REN_B is held at 1 at all times.
- Driven IO value is 8'h00 wherever not specified above.
- rst mid-operation: reset values on the next edge. No command completion to either flash is attempted.
- start coinciding with done: ignored. A new start is accepted only in IDLE.

Test Plan:
- Defaults; start, first_page = 0, page_count = 1; A model returns byte i = i[7:0]; RB drops 3 cycles after last strobe, busy 20 cycles -> B sees 80h, 00h, 00h, 00h, 512 bytes 00..FF x2, 10h; then done pulse, pages_done = 1, timeout_err = 0.
- first_page = 510, page_count = 3 -> row addresses 510 (FEh, 01h), 511 (FFh, 01h), 0 (00h, 00h); pages_done = 3; exactly one done pulse.
- page_count = 0 -> done pulse 1 cycle after start, busy never 1, no WEN/CLE toggles.
- RB_TIMEOUT = 64, F_RB_B stuck 1 after PROG -> ABORT after 64 cycles in WAIT_B; timeout_err = 1; pages_done = 0; next start clears timeout_err.
- PAGE_BYTES = 16, ROW_AW = 17, COL_CYC = 2 -> 5 address bytes, with the last byte = {7'b0, page[16]}; 32 XFER cycles; data matches A.
- rst asserted mid-XFER -> next cycle all outputs at reset values, busy = 0; a following start begins cleanly with a CMD phase.
